// File: rtl/debugger_tx_pkg.sv
// Shared definitions for the UART debug link: FSM state encodings, frame start byte, receiver command codes.
// The optional trailing checksum byte is enabled by defining DEBUGGER_TX_CHECKSUM_EN.
package debugger_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HEADER   = 3'd1,
      ST_PAYLOAD  = 3'd2,
      ST_CHECKSUM = 3'd3,
      ST_DONE     = 3'd4
   } tx_state_t;

   localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'b00,
      CMD_STEP  = 2'b01,
      CMD_RUN   = 2'b10,
      CMD_RESET = 2'b11
   } dbg_cmd_t;

   // Index width for a byte count, never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debugger_tx_byte_sel.sv
// Selects byte idx out of the captured snapshot; byte k lives at snap[8k+7:8k].
module debugger_tx_byte_sel
   import debugger_tx_pkg::*;
#(
   parameter int DUMP_BYTES = 176,
   parameter int IDX_W      = idx_width(DUMP_BYTES)
) (
   input  logic [8*DUMP_BYTES-1:0] snap,
   input  logic [IDX_W-1:0]        idx,
   output logic [7:0]              byte_out
);

   always_comb begin
      byte_out = '0;
      for (int k = 0; k < DUMP_BYTES; k++) begin
         if (idx == k[IDX_W-1:0]) begin
            byte_out = snap[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/debugger_tx.sv
// Debug-link transmitter: on a send_data rising edge, frames the pipeline snapshot into the UART TX FIFO.
// Define DEBUGGER_TX_CHECKSUM_EN to append an XOR-of-payload checksum byte after the payload.
module debugger_tx
   import debugger_tx_pkg::*;
#(
   parameter int         DUMP_BYTES  = 176,
   parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
   input  logic                    clk,
   input  logic                    global_reset,
   input  logic                    send_data,
   input  logic [8*DUMP_BYTES-1:0] dump_data,
   input  logic                    tx_full,
   output logic [7:0]              w_data,
   output logic                    wr_uart,
   output logic                    data_sent,
   output logic                    busy
);

   localparam int              IDX_W    = idx_width(DUMP_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_BYTES - 1);

   tx_state_t               state;
   logic                    send_q;
   logic [IDX_W-1:0]        idx;
   logic [8*DUMP_BYTES-1:0] snap;
   logic [7:0]              cur_byte;
   logic                    start;
`ifdef DEBUGGER_TX_CHECKSUM_EN
   logic [7:0]              chk;
`endif

   // Only a fresh rising edge seen while idle opens a frame; held levels and mid-frame edges are dropped.
   assign start = send_data && !send_q && (state == ST_IDLE);

   debugger_tx_byte_sel #(
      .DUMP_BYTES (DUMP_BYTES),
      .IDX_W      (IDX_W)
   ) u_byte_sel (
      .snap     (snap),
      .idx      (idx),
      .byte_out (cur_byte)
   );

   // Snapshot is frozen at the start edge so later dump_data changes cannot tear the frame.
   always_ff @(posedge clk) begin
      if (start) begin
         snap <= dump_data;
      end
   end

   always_ff @(posedge clk) begin
      if (global_reset) begin
         state     <= ST_IDLE;
         idx       <= '0;
         wr_uart   <= 1'b0;
         data_sent <= 1'b0;
         busy      <= 1'b0;
         w_data    <= '0;
         send_q    <= 1'b0;
`ifdef DEBUGGER_TX_CHECKSUM_EN
         chk       <= '0;
`endif
      end else begin
         send_q    <= send_data;
         wr_uart   <= 1'b0;
         data_sent <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= ST_HEADER;
`ifdef DEBUGGER_TX_CHECKSUM_EN
                  chk   <= '0;
`endif
               end
            end
            ST_HEADER: begin
               if (!tx_full) begin
                  wr_uart <= 1'b1;
                  w_data  <= HEADER_BYTE;
                  state   <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (!tx_full) begin
                  wr_uart <= 1'b1;
                  w_data  <= cur_byte;
`ifdef DEBUGGER_TX_CHECKSUM_EN
                  chk     <= chk ^ cur_byte;
`endif
                  if (idx == LAST_IDX) begin
`ifdef DEBUGGER_TX_CHECKSUM_EN
                     state <= ST_CHECKSUM;
`else
                     state <= ST_DONE;
`endif
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
`ifdef DEBUGGER_TX_CHECKSUM_EN
            ST_CHECKSUM: begin
               if (!tx_full) begin
                  wr_uart <= 1'b1;
                  w_data  <= chk;
                  state   <= ST_DONE;
               end
            end
`endif
            ST_DONE: begin
               data_sent <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
